// File: rtl/bitmat_pkg.sv
// bitmat_pkg: shared phase/op encodings and cell indexing for the bit-matrix scheduler
package bitmat_pkg;
  typedef enum logic [1:0] {
    PH_INIT  = 2'b00,
    PH_LOAD  = 2'b01,
    PH_QUERY = 2'b10
  } phase_t;
  localparam logic OP_SET  = 1'b0;
  localparam logic OP_READ = 1'b1;
  function automatic logic [3:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
    return {y, x};
  endfunction
endpackage

// File: rtl/bitmat_rr_arbiter.sv
// bitmat_rr_arbiter: combinational round-robin pick starting at ptr with wrap-around
module bitmat_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/bitmat_sched.sv
// bitmat_sched: phased, round-robin shared access to a 4x4 bit-matrix store
module bitmat_sched
  import bitmat_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LOAD_CNT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_op,
  input  logic [2*NREQ-1:0] req_x,
  input  logic [2*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   gnt,
  output logic              rdata,
  output logic              rvalid,
  output logic [1:0]        phase,
  output logic [15:0]       mat
);
  localparam int CW = $clog2(LOAD_CNT + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  phase_t st, st_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, gi;
  logic [NREQ-1:0] elig, agnt;
  logic [1:0] gx, gy;
  logic [3:0] ci;
  logic wr, rd;
  always_comb elig = (st == PH_LOAD) ? (req & ~req_op) : (st == PH_QUERY) ? (req & req_op) : '0;
  bitmat_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .elig(elig),
    .ptr (ptr),
    .gnt (agnt),
    .idx (gi)
  );
  assign gnt = restart ? '0 : agnt;
  assign gx = req_x[2*gi +: 2];
  assign gy = req_y[2*gi +: 2];
  assign ci = cell_idx(gx, gy);
  assign wr = (|gnt) && (st == PH_LOAD);
  assign rd = (|gnt) && (st == PH_QUERY);
  assign phase = st;
  always_comb st_n = restart ? PH_INIT :
                     (st == PH_INIT) ? PH_LOAD :
                     (wr && cnt == CW'(LOAD_CNT - 1)) ? PH_QUERY : st;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= PH_INIT;
    else st <= st_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mat <= '0;
      cnt <= '0;
      ptr <= '0;
      rdata <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= mat[ci];
      if (restart) begin
        mat <= '0;
        cnt <= '0;
        ptr <= '0;
      end else begin
        if (wr) mat[ci] <= 1'b1;
        if (wr && cnt != CW'(LOAD_CNT)) cnt <= cnt + 1'b1;
        if (|gnt) ptr <= (gi == PW'(NREQ - 1)) ? '0 : gi + 1'b1;
      end
    end
endmodule

// File: tb/tb_bitmat_sched.sv
// tb_bitmat_sched: scenario-driven scoreboard bench for bitmat_sched
module tb_bitmat_sched;
  import bitmat_pkg::*;
  logic clk = 1'b0;
  logic rst, restart;
  logic [1:0] req, req_op, gnt, phase;
  logic [3:0] req_x, req_y;
  logic rdata, rvalid;
  logic [15:0] mat, mm;
  logic q[$];
  logic e;
  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bitmat_sched dut (
    .clk(clk), .rst(rst), .restart(restart), .req(req), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .phase(phase), .mat(mat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic op, input logic [1:0] x, input logic [1:0] y);
    req[0] = r; req_op[0] = op; req_x[1:0] = x; req_y[1:0] = y;
  endtask

  task automatic set1(input logic r, input logic op, input logic [1:0] x, input logic [1:0] y);
    req[1] = r; req_op[1] = op; req_x[3:2] = x; req_y[3:2] = y;
  endtask

  task automatic do_restart;
    req = '0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    mm = '0;
    tick();
  endtask

  task automatic test_reset;
    repeat (2) tick();
    vec++; if (phase !== 2'b00) begin errs++; $display("FAIL reset_phase got %b want 00", phase); end
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt got %b want 00", gnt); end
    vec++; if (mat !== 16'h0000) begin errs++; $display("FAIL reset_mat got %h want 0000", mat); end
    vec++; if (rvalid !== 1'b0 || rdata !== 1'b0) begin errs++; $display("FAIL reset_rd got %b/%b want 0/0", rvalid, rdata); end
    rst = 1'b0;
    tick();
    vec++; if (phase !== 2'b01) begin errs++; $display("FAIL reset_release_phase got %b want 01", phase); end
    mm = '0;
  endtask

  task automatic test_single_load;
    logic [1:0] xs[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [1:0] ys[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, OP_SET, xs[i], ys[i]);
      #4;
      vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL load_gnt[%0d] got %b want 01", i, gnt); end
      vec++; if (phase !== 2'b01) begin errs++; $display("FAIL load_phase[%0d] got %b want 01", i, phase); end
      mm[cell_idx(xs[i], ys[i])] = 1'b1;
      tick();
    end
    set0(1'b0, OP_SET, 2'd0, 2'd0);
    vec++; if (phase !== 2'b10) begin errs++; $display("FAIL load_to_query got %b want 10", phase); end
    vec++; if (mat !== 16'h9429) begin errs++; $display("FAIL load_mat got %h want 9429", mat); end
  endtask

  task automatic test_query_mixed;
    set0(1'b1, OP_SET, 2'd1, 2'd0);
    set1(1'b1, OP_READ, 2'd1, 2'd1);
    #4;
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL mixed_gnt0 got %b want 10", gnt); end
    q.push_back(mm[cell_idx(2'd1, 2'd1)]);
    tick();
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL mixed_rvalid0 got %b want 1", rvalid); end
    e = q.pop_front();
    vec++; if (rdata !== e) begin errs++; $display("FAIL mixed_rdata0 got %b want %b", rdata, e); end
    set1(1'b1, OP_READ, 2'd2, 2'd1);
    #4;
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL mixed_gnt1 got %b want 10", gnt); end
    q.push_back(mm[cell_idx(2'd2, 2'd1)]);
    tick();
    vec++; if (rvalid !== 1'b1) begin errs++; $display("FAIL mixed_rvalid1 got %b want 1", rvalid); end
    e = q.pop_front();
    vec++; if (rdata !== e) begin errs++; $display("FAIL mixed_rdata1 got %b want %b", rdata, e); end
    set1(1'b0, OP_READ, 2'd0, 2'd0);
    #4;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL mixed_write_held got %b want 00", gnt); end
    tick();
    vec++; if (rvalid !== 1'b0) begin errs++; $display("FAIL mixed_rvalid_pulse got %b want 0", rvalid); end
    vec++; if (mat !== mm) begin errs++; $display("FAIL mixed_mat got %h want %h", mat, mm); end
    set0(1'b0, OP_SET, 2'd0, 2'd0);
  endtask

  task automatic test_restart;
    logic [1:0] xs[3] = '{2'd1, 2'd2, 2'd3};
    set1(1'b1, OP_READ, 2'd3, 2'd3);
    #4;
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL rst_read_gnt got %b want 10", gnt); end
    q.push_back(mm[cell_idx(2'd3, 2'd3)]);
    tick();
    e = q.pop_front();
    vec++; if (rvalid !== 1'b1 || rdata !== e) begin errs++; $display("FAIL rst_read got %b/%b want 1/%b", rvalid, rdata, e); end
    set0(1'b1, OP_SET, 2'd0, 2'd2);
    restart = 1'b1;
    #3;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL restart_gnt_q got %b want 00", gnt); end
    tick();
    restart = 1'b0;
    mm = '0;
    vec++; if (mat !== 16'h0000 || phase !== 2'b00) begin errs++; $display("FAIL restart_q got mat %h phase %b want 0000 00", mat, phase); end
    vec++; if (rvalid !== 1'b0 || rdata !== e) begin errs++; $display("FAIL restart_rd got %b/%b want 0/%b", rvalid, rdata, e); end
    set1(1'b0, OP_READ, 2'd0, 2'd0);
    set0(1'b0, OP_SET, 2'd0, 2'd0);
    tick();
    vec++; if (phase !== 2'b01) begin errs++; $display("FAIL restart_load got %b want 01", phase); end
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, OP_SET, xs[i], 2'd0);
      #4;
      vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL restart_wr_gnt[%0d] got %b want 01", i, gnt); end
      mm[cell_idx(xs[i], 2'd0)] = 1'b1;
      tick();
    end
    vec++; if (mat !== mm) begin errs++; $display("FAIL restart_partial_mat got %h want %h", mat, mm); end
    set0(1'b1, OP_SET, 2'd0, 2'd2);
    restart = 1'b1;
    #4;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL restart_gnt_l got %b want 00", gnt); end
    tick();
    restart = 1'b0;
    mm = '0;
    vec++; if (mat !== 16'h0000 || phase !== 2'b00) begin errs++; $display("FAIL restart_l got mat %h phase %b want 0000 00", mat, phase); end
    #4;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL init_gnt got %b want 00", gnt); end
    tick();
    vec++; if (phase !== 2'b01 || mat !== 16'h0000) begin errs++; $display("FAIL init_exit got phase %b mat %h want 01 0000", phase, mat); end
  endtask

  task automatic test_dup_writes;
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, OP_SET, 2'd2, 2'd0);
      #4;
      vec++; if (gnt !== 2'b01 || phase !== 2'b01) begin errs++; $display("FAIL dup[%0d] got gnt %b phase %b want 01 01", i, gnt, phase); end
      tick();
    end
    set0(1'b0, OP_SET, 2'd0, 2'd0);
    vec++; if (phase !== 2'b10) begin errs++; $display("FAIL dup_phase got %b want 10", phase); end
    vec++; if (mat !== 16'h0004) begin errs++; $display("FAIL dup_mat got %h want 0004", mat); end
  endtask

  task automatic test_fairness;
    logic [1:0] want;
    do_restart();
    set0(1'b1, OP_SET, 2'd0, 2'd1);
    set1(1'b1, OP_SET, 2'd1, 2'd2);
    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #4;
      vec++; if (gnt !== want) begin errs++; $display("FAIL fair_gnt[%0d] got %b want %b", i, gnt, want); end
      tick();
    end
    req = '0;
    vec++; if (phase !== 2'b10) begin errs++; $display("FAIL fair_phase got %b want 10", phase); end
    vec++; if (mat !== 16'h0210) begin errs++; $display("FAIL fair_mat got %h want 0210", mat); end
  endtask

  task automatic test_write_priority;
    do_restart();
    set0(1'b1, OP_SET, 2'd0, 2'd0);
    #4;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL prio_first got %b want 01", gnt); end
    tick();
    set1(1'b1, OP_READ, 2'd1, 2'd1);
    #4;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL prio_write_wins got %b want 01", gnt); end
    tick();
    vec++; if (rvalid !== 1'b0 || mat !== 16'h0001) begin errs++; $display("FAIL prio_effect got rvalid %b mat %h want 0 0001", rvalid, mat); end
    set0(1'b0, OP_SET, 2'd0, 2'd0);
    #4;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL prio_read_held got %b want 00", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_async_abort;
    do_restart();
    set0(1'b1, OP_SET, 2'd3, 2'd3);
    #4;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL abort_pre_gnt got %b want 01", gnt); end
    tick();
    vec++; if (mat !== 16'h8000) begin errs++; $display("FAIL abort_pre_mat got %h want 8000", mat); end
    set0(1'b1, OP_SET, 2'd2, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    vec++; if (mat !== 16'h0000 || phase !== 2'b00 || gnt !== 2'b00) begin errs++; $display("FAIL abort_async got mat %h phase %b gnt %b want 0000 00 00", mat, phase, gnt); end
    vec++; if (rvalid !== 1'b0 || rdata !== 1'b0) begin errs++; $display("FAIL abort_rd got %b/%b want 0/0", rvalid, rdata); end
    #2;
    rst = 1'b0;
    tick();
    vec++; if (phase !== 2'b01 || mat !== 16'h0000) begin errs++; $display("FAIL abort_release got phase %b mat %h want 01 0000", phase, mat); end
    #4;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL abort_regrant got %b want 01", gnt); end
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    req = '0;
    req_op = '0;
    req_x = '0;
    req_y = '0;
    mm = '0;
    test_reset();
    test_single_load();
    test_query_mixed();
    test_restart();
    test_dup_writes();
    test_fairness();
    test_write_priority();
    test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
